// File: rtl/daylight_dimmer.sv
// Daylight sensor conditioning (sync + debounce) driving PWM-dimmed status LEDs and a blinking WARN.
// Define BLASTIT_DAYLIGHT_FADE_EN to ramp DUTY between day and night levels instead of jumping.
//
// state      | meaning
// S_DAY      | settled daylight, IS_DAY=1
// S_TO_NIGHT | input low, counting toward night, IS_DAY still 1
// S_NIGHT    | settled night, IS_DAY=0
// S_TO_DAY   | input high, counting toward day, IS_DAY still 0
module daylight_dimmer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PWM_BITS        = 8,
  parameter int DAY_DUTY        = 255,
  parameter int NIGHT_DUTY      = 32,
  parameter int NUM_LED         = 4,
  parameter int BLINK_CYCLES    = 25000000,
  parameter int RAMP_CYCLES     = 50000
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                DAYLIGHT,
  input  logic                WARN_REQ,
  output logic                WARN,
  output logic [NUM_LED-1:0]  LED,
  output logic                IS_DAY,
  output logic [PWM_BITS-1:0] DUTY
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BL_W = $clog2(BLINK_CYCLES + 1);
  localparam logic [DB_W-1:0]     DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0]     BL_LAST = BL_W'(BLINK_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] DAY_D   = PWM_BITS'(DAY_DUTY);
  localparam logic [PWM_BITS-1:0] NIGHT_D = PWM_BITS'(NIGHT_DUTY);

  if (DEBOUNCE_CYCLES < 1 || BLINK_CYCLES < 1 || RAMP_CYCLES < 1) begin : g_bad_param
    $error("daylight_dimmer: DEBOUNCE_CYCLES, BLINK_CYCLES and RAMP_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {S_DAY, S_TO_NIGHT, S_NIGHT, S_TO_DAY} state_t;

  state_t              state, state_nx;
  logic [DB_W-1:0]     db_cnt, db_cnt_nx;
  logic                sync_meta, sync_day;
  logic                is_day;
  logic [PWM_BITS-1:0] target, duty_q, duty_lat, pwm_cnt;
  logic                pwm_on;
  logic [BL_W-1:0]     blink_cnt;
  logic                blink_phase;
  logic [NUM_LED-1:0]  led_pattern;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_meta <= 1'b1;
      sync_day  <= 1'b1;
    end else begin
      sync_meta <= DAYLIGHT;
      sync_day  <= sync_meta;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= S_DAY;
      db_cnt <= '0;
    end else begin
      state  <= state_nx;
      db_cnt <= db_cnt_nx;
    end
  end

  // A single-cycle debounce skips the counting states so latency stays DEBOUNCE_CYCLES+2.
  always_comb begin
    state_nx  = state;
    db_cnt_nx = db_cnt;
    case (state)
      S_DAY: begin
        if (!sync_day) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nx  = S_NIGHT;
            db_cnt_nx = '0;
          end else begin
            state_nx  = S_TO_NIGHT;
            db_cnt_nx = DB_W'(1);
          end
        end
      end
      S_TO_NIGHT: begin
        if (sync_day) begin
          state_nx  = S_DAY;
          db_cnt_nx = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nx  = S_NIGHT;
          db_cnt_nx = '0;
        end else begin
          db_cnt_nx = db_cnt + DB_W'(1);
        end
      end
      S_NIGHT: begin
        if (sync_day) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nx  = S_DAY;
            db_cnt_nx = '0;
          end else begin
            state_nx  = S_TO_DAY;
            db_cnt_nx = DB_W'(1);
          end
        end
      end
      S_TO_DAY: begin
        if (!sync_day) begin
          state_nx  = S_NIGHT;
          db_cnt_nx = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nx  = S_DAY;
          db_cnt_nx = '0;
        end else begin
          db_cnt_nx = db_cnt + DB_W'(1);
        end
      end
      default: begin
        state_nx  = S_DAY;
        db_cnt_nx = '0;
      end
    endcase
  end

  always_comb begin
    is_day = (state == S_DAY) || (state == S_TO_NIGHT);
    target = is_day ? DAY_D : NIGHT_D;
  end

`ifdef BLASTIT_DAYLIGHT_FADE_EN
  localparam int RP_W = $clog2(RAMP_CYCLES + 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(RAMP_CYCLES - 1);

  logic [RP_W-1:0] ramp_cnt;

  // Step direction is taken from the live target, so a reversal mid-ramp just turns around.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      duty_q   <= DAY_D;
      ramp_cnt <= '0;
    end else if (duty_q == target) begin
      ramp_cnt <= '0;
    end else if (ramp_cnt == RP_LAST) begin
      ramp_cnt <= '0;
      duty_q   <= (duty_q < target) ? duty_q + PWM_BITS'(1) : duty_q - PWM_BITS'(1);
    end else begin
      ramp_cnt <= ramp_cnt + RP_W'(1);
    end
  end
`else
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) duty_q <= DAY_D;
    else          duty_q <= target;
  end
`endif

  // Duty is only sampled at the period boundary so a change never truncates a pulse.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pwm_cnt  <= '0;
      duty_lat <= DAY_D;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (pwm_cnt == '1) duty_lat <= duty_q;
    end
  end

  assign pwm_on = (pwm_cnt < duty_lat);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (!WARN_REQ) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BL_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BL_W'(1);
    end
  end

  always_comb begin
    led_pattern = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      led_pattern[i] = (i % 2 == 0) ? is_day : ~is_day;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      LED  <= '0;
      WARN <= 1'b0;
    end else begin
      LED  <= pwm_on ? led_pattern : '0;
      WARN <= WARN_REQ & blink_phase & pwm_on;
    end
  end

  assign IS_DAY = is_day;
  assign DUTY   = duty_q;

endmodule
